// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode stage between fetch and ALU.
// Accepts instruction words over valid/ready, produces one registered ALU
// beat (operands + operation) with 1-cycle latency at full throughput.
// LDW assembles a DATA_W-wide immediate from EXT_BEATS extension words.
// Optional feature macro: DECODE_ILLEGAL_EN adds the 'illegal' pulse output.
module decode_stage #(
    parameter int DATA_W = 8,
    parameter int IR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [DATA_W-1:0] acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [2:0]        alu_operation
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    localparam int IMM_W     = IR_W - 4;
    localparam int EXT_BEATS = (DATA_W + IR_W - 1) / IR_W;
    localparam int WORD_W    = EXT_BEATS * IR_W;
    localparam int CNT_W     = (EXT_BEATS > 1) ? $clog2(EXT_BEATS) : 1;

    typedef enum logic {
        S_IDLE,
        S_EXT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110
    } alu_op_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word_nxt;
    logic [WORD_W-1:0]   w_word_fill;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    alu_op_t             r_oper;
    logic                w_load;
    logic [DATA_W-1:0]   w_op1_nxt;
    logic [DATA_W-1:0]   w_op2_nxt;
    alu_op_t             w_oper_nxt;
    logic                w_in_ready;
    logic                w_accept;
    logic [3:0]          w_opcode;
    logic [DATA_W-1:0]   w_imm;

    // The stage can take a word whenever its output slot is empty or draining.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_opcode   = in_ir[IR_W-1 -: 4];
    assign w_imm      = DATA_W'(in_ir[IMM_W-1:0]);

    // Next-state, extension-word assembly and next-beat decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_load      = 1'b0;
        w_op1_nxt   = r_op1;
        w_op2_nxt   = r_op2;
        w_oper_nxt  = r_oper;
        w_word_fill = r_word;
        w_word_fill[r_cnt*IR_W +: IR_W] = in_ir;

        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    case (w_opcode)
                        4'h1: begin
                            w_load     = 1'b1;
                            w_op1_nxt  = w_imm;
                            w_op2_nxt  = '0;
                            w_oper_nxt = ALU_ADD;
                        end
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9: begin
                            w_load    = 1'b1;
                            w_op1_nxt = acc;
                            w_op2_nxt = w_imm;
                            case (w_opcode)
                                4'h2:    w_oper_nxt = ALU_ADD;
                                4'h3:    w_oper_nxt = ALU_SUB;
                                4'h4:    w_oper_nxt = ALU_AND;
                                4'h5:    w_oper_nxt = ALU_OR;
                                4'h6:    w_oper_nxt = ALU_XOR;
                                4'h8:    w_oper_nxt = ALU_SHL;
                                default: w_oper_nxt = ALU_SHR;
                            endcase
                        end
                        4'h7: begin
                            w_state_nxt = S_EXT;
                            w_cnt_nxt   = '0;
                            w_word_nxt  = '0;
                        end
                        // NOP and the illegal range are consumed without a beat.
                        default: ;
                    endcase
                end
                S_EXT: begin
                    if (r_cnt == CNT_W'(EXT_BEATS - 1)) begin
                        // Last extension word: bits above DATA_W are dropped.
                        w_load      = 1'b1;
                        w_op1_nxt   = w_word_fill[DATA_W-1:0];
                        w_op2_nxt   = '0;
                        w_oper_nxt  = ALU_ADD;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_word_nxt  = '0;
                    end else begin
                        w_word_nxt = w_word_fill;
                        w_cnt_nxt  = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and registered output beat; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_oper      <= ALU_ADD;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_op1       <= w_op1_nxt;
                r_op2       <= w_op2_nxt;
                r_oper      <= w_oper_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic r_illegal;

    // One-cycle pulse after an accepted opcode in 0xA-0xF, independent of out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && (r_state == S_IDLE) && (w_opcode >= 4'hA);
        end
    end

    assign illegal = r_illegal;
`endif

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign alu_op1       = r_op1;
    assign alu_op2       = r_op2;
    assign alu_operation = r_oper;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (DATA_W=16, IR_W=8, so
// LDW takes two extension words). The driver feeds a reference model that
// pushes expected beats; a monitor pops them as the DUT hands beats over.
module tb_decode_stage;

    localparam int DATA_W    = 16;
    localparam int IR_W      = 8;
    localparam int EXT_BEATS = (DATA_W + IR_W - 1) / IR_W;

    typedef struct {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [2:0]        op;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IR_W-1:0]   in_ir;
    logic [DATA_W-1:0] acc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [2:0]        alu_operation;
`ifdef DECODE_ILLEGAL_EN
    logic              illegal;
    logic              exp_ill;
`endif

    int n_checks;
    int n_fail;

    beat_t sb[$];

    // reference model state
    bit          m_ext;
    int          m_idx;
    logic [63:0] m_word;

    decode_stage #(.DATA_W(DATA_W), .IR_W(IR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ir         (in_ir),
        .acc           (acc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegal       (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] o1, input logic [DATA_W-1:0] o2, input logic [2:0] op);
        beat_t b;
        b.op1 = o1;
        b.op2 = o2;
        b.op  = op;
        sb.push_back(b);
    endtask

    // Behavioural meaning of one accepted word.
    task automatic model_accept(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] a);
        int unsigned opc;
        logic [DATA_W-1:0] imm;
        opc = int'(ir) / 16;
        imm = DATA_W'(int'(ir) % 16);
        if (m_ext) begin
            m_word = m_word + (64'(ir) << (m_idx * IR_W));
            m_idx++;
            if (m_idx == EXT_BEATS) begin
                push(m_word[DATA_W-1:0], '0, 3'd0);
                m_ext = 0;
            end
        end else begin
            case (opc)
                1:             push(imm, '0, 3'd0);
                2, 3, 4, 5, 6: push(a, imm, 3'(opc - 2));
                8:             push(a, imm, 3'd5);
                9:             push(a, imm, 3'd6);
                7: begin
                    m_ext  = 1;
                    m_idx  = 0;
                    m_word = '0;
                end
                10, 11, 12, 13, 14, 15: begin
`ifdef DECODE_ILLEGAL_EN
                    exp_ill = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus; called and returning at posedge+1.
    task automatic cycle(input logic v, input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] a,
                         input logic ordy);
        in_valid  = v;
        in_ir     = ir;
        acc       = a;
        out_ready = ordy;
        @(negedge clk);
`ifdef DECODE_ILLEGAL_EN
        check("illegal_pulse", 64'(illegal), 64'(exp_ill));
        exp_ill = 1'b0;
`endif
        if (rst_n && in_valid && in_ready) model_accept(ir, a);
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input logic [DATA_W-1:0] o1,
                              input logic [DATA_W-1:0] o2, input logic [2:0] op);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_op1"}, 64'(alu_op1), 64'(o1));
        check({name, "_op2"}, 64'(alu_op2), 64'(o2));
        check({name, "_oper"}, 64'(alu_operation), 64'(op));
    endtask

    // Asynchronous reset pulse mid-cycle; called and returning at posedge+1.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_op1", 64'(alu_op1), 64'd0);
        check("rst_op2", 64'(alu_op2), 64'd0);
        check("rst_oper", 64'(alu_operation), 64'd0);
        sb.delete();
        m_ext = 0;
        m_idx = 0;
        m_word = '0;
`ifdef DECODE_ILLEGAL_EN
        exp_ill = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Monitor: pops an expected beat on every handshake, checks holds while stalled.
    initial begin
        beat_t       exp_b;
        logic [34:0] held;
        bit          have_held;
        have_held = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_held = 0;
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h/%0h/%0h expected none at %0t",
                             alu_op1, alu_op2, alu_operation, $time);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", {29'd0, alu_op1, alu_op2, alu_operation},
                          {29'd0, exp_b.op1, exp_b.op2, exp_b.op});
                end
                have_held = 0;
            end else if (out_valid) begin
                if (have_held)
                    check("hold", 64'({alu_op1, alu_op2, alu_operation}), 64'(held));
                held = {alu_op1, alu_op2, alu_operation};
                have_held = 1;
            end else begin
                have_held = 0;
            end
        end
    end

    initial begin
        int drain;
        n_checks  = 0;
        n_fail    = 0;
        m_ext     = 0;
        m_idx     = 0;
        m_word    = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ir     = '0;
        acc       = '0;
        out_ready = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        exp_ill   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_op1", 64'(alu_op1), 64'd0);
        check("init_oper", 64'(alu_operation), 64'd0);
        rst_n = 1'b1;
        check("init_in_ready", 64'(in_ready), 64'd1);

        // LDI 3
        cycle(1'b1, 8'h13, 16'hBEEF, 1'b1);
        check_beat("ldi", 16'h0003, 16'h0000, 3'd0);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);

        // ADDI with stalled consumer: beat and in_ready held
        cycle(1'b1, 8'h29, 16'h0005, 1'b0);
        check_beat("addi_stall", 16'h0005, 16'h0009, 3'd0);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 8'h11, 16'h0, 1'b0);
        check_beat("addi_held", 16'h0005, 16'h0009, 3'd0);
        check("stall_in_ready2", 64'(in_ready), 64'd0);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);
        check("stall_released", 64'(out_valid), 64'd0);

        // Wide load over two extension words
        cycle(1'b1, 8'h70, 16'h0, 1'b1);
        check("ldw_no_beat0", 64'(out_valid), 64'd0);
        cycle(1'b1, 8'h34, 16'h0, 1'b1);
        check("ldw_no_beat1", 64'(out_valid), 64'd0);
        cycle(1'b1, 8'h12, 16'h0, 1'b1);
        check_beat("ldw", 16'h1234, 16'h0000, 3'd0);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);

        // Illegal opcode, then SUBI
        cycle(1'b1, 8'hA0, 16'h0, 1'b1);
        check("illegal_no_beat", 64'(out_valid), 64'd0);
        cycle(1'b1, 8'h31, 16'h0004, 1'b1);
        check_beat("subi", 16'h0004, 16'h0001, 3'd1);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);

        // Reset in the middle of a wide load discards the partial word
        cycle(1'b1, 8'h70, 16'h0, 1'b1);
        cycle(1'b1, 8'hFF, 16'h0, 1'b1);
        do_reset();
        cycle(1'b1, 8'h15, 16'h0, 1'b1);
        check_beat("post_rst_ldi", 16'h0005, 16'h0000, 3'd0);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);

        // Reset with a held beat pending
        cycle(1'b1, 8'h52, 16'h00F0, 1'b0);
        check_beat("ori_pending", 16'h00F0, 16'h0002, 3'd3);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < 7));
        end

        // Drain
        drain = 0;
        while (sb.size() != 0 && drain < 20) begin
            cycle(1'b0, 8'h00, 16'h0, 1'b1);
            drain++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        cycle(1'b0, 8'h00, 16'h0, 1'b1);
        check("final_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
